// File: rtl/lcd_nibble_driver_pkg.sv
// Shared definitions for the character-LCD nibble driver: state encodings,
// strobe phases, init/config tables and the timer-load helper.
package lcd_nibble_driver_pkg;

  localparam int unsigned TIMER_W = 20;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_NIB,
    ST_INIT_WAIT,
    ST_SEND_HI,
    ST_GAP_NIB,
    ST_SEND_LO,
    ST_GAP_CMD,
    ST_IDLE,
    ST_LATCH
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EHIGH,
    PH_HOLD
  } phase_t;

  // Commands that need the long settle time (return-home ignores bit 0).
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Timer is loaded with cycles-1 so a state lasts exactly max(cycles,1).
  function automatic logic [TIMER_W-1:0] load_value(input int unsigned cycles);
    logic [31:0] w_tmp;
    w_tmp = (cycles == 0) ? 32'd0 : cycles - 32'd1;
    return w_tmp[TIMER_W-1:0];
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

  // Power-up 8-bit/4-bit switch nibbles: 3, 3, 3, 2.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  // Function set, entry mode, display on, clear.
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_driver_if.sv
// CPU request/handshake and LCD pin bundle for the nibble driver.
interface lcd_nibble_driver_if;
  import lcd_nibble_driver_pkg::*;

  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady;
  logic       oInitDone;
  logic [3:0] oLCD_Data;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;

  modport master (
    output iData, iRS, iValid,
    input  oReady, oInitDone, oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW
  );

  modport slave (
    input  iData, iRS, iValid,
    output oReady, oInitDone, oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// Single 20-bit down-counter; done while the count sits at zero.
module lcd_delay_timer
  import lcd_nibble_driver_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RESET_VALUE = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_value,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// Spartan-3E character LCD driver: power-up init, configuration bytes,
// then one CPU byte at a time sent as two HD44780 nibble strobes.
module lcd_nibble_driver
  import lcd_nibble_driver_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EHIGH = 12,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input logic                Clock,
  input logic                Reset,
  lcd_nibble_driver_if.slave bus
);

  state_t             r_state, w_state_nxt;
  phase_t             r_phase, w_phase_nxt;
  logic [1:0]         r_idx, w_idx_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_rs, w_rs_nxt;
  logic               r_cfg, w_cfg_nxt;
  logic               r_init_done, w_init_done_nxt;
  logic               w_load;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_done;
  logic [3:0]         w_lcd_data;
  logic               w_lcd_e;
  logic               w_lcd_rs;

  lcd_delay_timer #(
    .RESET_VALUE(load_value(T_PWRUP))
  ) u_timer (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  // State, strobe phase and captured byte registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_PWRUP;
      r_phase     <= PH_SETUP;
      r_idx       <= '0;
      r_byte      <= '0;
      r_rs        <= 1'b0;
      r_cfg       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_idx       <= w_idx_nxt;
      r_byte      <= w_byte_nxt;
      r_rs        <= w_rs_nxt;
      r_cfg       <= w_cfg_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next-state and timer reload: every state/phase entry reloads the timer.
  // Config bytes reuse the SEND_HI..GAP_CMD path with r_cfg marking them.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_idx_nxt       = r_idx;
    w_byte_nxt      = r_byte;
    w_rs_nxt        = r_rs;
    w_cfg_nxt       = r_cfg;
    w_init_done_nxt = r_init_done;
    w_load          = 1'b0;
    w_load_val      = '0;

    unique case (r_state)
      ST_PWRUP: begin
        if (w_done) begin
          w_state_nxt = ST_INIT_NIB;
          w_phase_nxt = PH_SETUP;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
          w_load_val  = load_value(T_SETUP);
        end
      end

      ST_INIT_NIB, ST_SEND_HI, ST_SEND_LO: begin
        if (w_done) begin
          w_load = 1'b1;
          unique case (r_phase)
            PH_SETUP: begin
              w_phase_nxt = PH_EHIGH;
              w_load_val  = load_value(T_EHIGH);
            end
            PH_EHIGH: begin
              w_phase_nxt = PH_HOLD;
              w_load_val  = load_value(1);
            end
            default: begin
              w_phase_nxt = PH_SETUP;
              case (r_state)
                ST_INIT_NIB: begin
                  w_state_nxt = ST_INIT_WAIT;
                  w_load_val  = (r_idx == 2'd0) ? load_value(T_INIT1) : load_value(T_INIT2);
                end
                ST_SEND_HI: begin
                  w_state_nxt = ST_GAP_NIB;
                  w_load_val  = load_value(T_NIB);
                end
                default: begin
                  w_state_nxt = ST_GAP_CMD;
                  w_load_val  = is_long_cmd(r_rs, r_byte) ? load_value(T_CLEAR) : load_value(T_CMD);
                end
              endcase
            end
          endcase
        end
      end

      ST_INIT_WAIT: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_load_val  = load_value(T_SETUP);
          w_phase_nxt = PH_SETUP;
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_SEND_HI;
            w_idx_nxt   = '0;
            w_cfg_nxt   = 1'b1;
            w_byte_nxt  = cfg_byte(2'd0);
            w_rs_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_INIT_NIB;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end
      end

      ST_GAP_NIB: begin
        if (w_done) begin
          w_state_nxt = ST_SEND_LO;
          w_phase_nxt = PH_SETUP;
          w_load      = 1'b1;
          w_load_val  = load_value(T_SETUP);
        end
      end

      ST_GAP_CMD: begin
        if (w_done) begin
          if (r_cfg && (r_idx != 2'd3)) begin
            w_state_nxt = ST_SEND_HI;
            w_phase_nxt = PH_SETUP;
            w_idx_nxt   = r_idx + 2'd1;
            w_byte_nxt  = cfg_byte(r_idx + 2'd1);
            w_load      = 1'b1;
            w_load_val  = load_value(T_SETUP);
          end else begin
            w_state_nxt     = ST_IDLE;
            w_cfg_nxt       = 1'b0;
            w_init_done_nxt = 1'b1;
          end
        end
      end

      ST_IDLE: begin
        if (bus.iValid) begin
          w_state_nxt = ST_LATCH;
          w_byte_nxt  = bus.iData;
          w_rs_nxt    = bus.iRS;
          w_load      = 1'b1;
          w_load_val  = load_value(0);
        end
      end

      ST_LATCH: begin
        if (w_done) begin
          w_state_nxt = ST_SEND_HI;
          w_phase_nxt = PH_SETUP;
          w_load      = 1'b1;
          w_load_val  = load_value(T_SETUP);
        end
      end

      default: begin
        w_state_nxt = ST_PWRUP;
      end
    endcase
  end

  // LCD pin decode: data only inside strobes, E only in the high phase.
  always_comb begin
    w_lcd_data = '0;
    w_lcd_e    = 1'b0;
    w_lcd_rs   = 1'b0;
    case (r_state)
      ST_INIT_NIB: begin
        w_lcd_data = init_nibble(r_idx);
        w_lcd_e    = (r_phase == PH_EHIGH);
      end
      ST_SEND_HI: begin
        w_lcd_data = r_byte[7:4];
        w_lcd_e    = (r_phase == PH_EHIGH);
        w_lcd_rs   = r_rs;
      end
      ST_GAP_NIB: begin
        w_lcd_rs   = r_rs;
      end
      ST_SEND_LO: begin
        w_lcd_data = r_byte[3:0];
        w_lcd_e    = (r_phase == PH_EHIGH);
        w_lcd_rs   = r_rs;
      end
      default: ;
    endcase
  end

  assign bus.oLCD_Data = w_lcd_data;
  assign bus.oLCD_E    = w_lcd_e;
  assign bus.oLCD_RS   = w_lcd_rs;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oReady    = (r_state == ST_IDLE);
  assign bus.oInitDone = r_init_done;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Bench for lcd_nibble_driver: an E-pulse monitor is compared with an
// expected pulse list built from the documented timing rules.
module tb_lcd_nibble_driver;

  localparam int P_PWRUP = 20;
  localparam int P_INIT1 = 10;
  localparam int P_INIT2 = 5;
  localparam int P_SETUP = 2;
  localparam int P_EHIGH = 3;
  localparam int P_NIB   = 4;
  localparam int P_CMD   = 8;
  localparam int P_CLEAR = 30;
  localparam int S       = P_SETUP + P_EHIGH + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lcd_nibble_driver_if bus();

  lcd_nibble_driver #(
    .T_PWRUP(P_PWRUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2), .T_SETUP(P_SETUP),
    .T_EHIGH(P_EHIGH), .T_NIB(P_NIB), .T_CMD(P_CMD), .T_CLEAR(P_CLEAR)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         rise;
    logic [3:0] data;
    logic       rs;
    int         width;
    bit         stable;
  } pulse_t;

  pulse_t obs_q[$];
  pulse_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [3:0] hist_d [64];
  logic       hist_rs[64];
  bit         prev_e = 1'b0;
  pulse_t     cur;

  // Pulse monitor: records rise edge, nibble, RS, width and whether data/RS
  // held from setup start through the hold cycle.
  always @(negedge clk) begin
    hist_d[cyc % 64]  = bus.oLCD_Data;
    hist_rs[cyc % 64] = bus.oLCD_RS;
    if (bus.oLCD_E === 1'b1) begin
      if (!prev_e) begin
        cur.rise   = cyc;
        cur.data   = bus.oLCD_Data;
        cur.rs     = bus.oLCD_RS;
        cur.width  = 0;
        cur.stable = 1'b1;
        for (int k = 1; k <= P_SETUP; k++)
          if (hist_d[(cyc + 64 - k) % 64] !== cur.data || hist_rs[(cyc + 64 - k) % 64] !== cur.rs)
            cur.stable = 1'b0;
      end
      cur.width++;
      if (bus.oLCD_Data !== cur.data || bus.oLCD_RS !== cur.rs) cur.stable = 1'b0;
    end else if (prev_e) begin
      if (bus.oLCD_Data !== cur.data || bus.oLCD_RS !== cur.rs) cur.stable = 1'b0;
      obs_q.push_back(cur);
    end
    prev_e = (bus.oLCD_E === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // ---- reference model: timing rules as plain arithmetic ----
  function automatic int gap_of(input logic [7:0] b, input logic rs);
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return P_CLEAR;
    return P_CMD;
  endfunction

  function automatic void exp_strobe(input int t, input logic [3:0] d, input logic rs);
    pulse_t p;
    p.rise   = t + P_SETUP;
    p.data   = d;
    p.rs     = rs;
    p.width  = P_EHIGH;
    p.stable = 1'b1;
    exp_q.push_back(p);
  endfunction

  // Byte whose hi-nibble setup starts at edge t; returns the edge oReady rises.
  function automatic int exp_byte(input int t, input logic [7:0] b, input logic rs);
    exp_strobe(t, b[7:4], rs);
    exp_strobe(t + S + P_NIB, b[3:0], rs);
    return t + 2 * S + P_NIB + gap_of(b, rs);
  endfunction

  // r = last clock edge seen with reset asserted; returns the edge IDLE is reached.
  function automatic int exp_init(input int r);
    int         t = r + P_PWRUP;
    int         waits[4] = '{P_INIT1, P_INIT2, P_INIT2, P_INIT2};
    logic [3:0] nib[4]   = '{4'h3, 4'h3, 4'h3, 4'h2};
    logic [7:0] cfg[4]   = '{8'h28, 8'h06, 8'h0C, 8'h01};
    for (int i = 0; i < 4; i++) begin
      exp_strobe(t, nib[i], 1'b0);
      t = t + S + waits[i];
    end
    for (int i = 0; i < 4; i++) t = exp_byte(t, cfg[i], 1'b0);
    return t;
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic compare_pulses(input string tag);
    pulse_t o, e;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_rise"},   o.rise,   e.rise);
      check({tag, "_data"},   32'(o.data), 32'(e.data));
      check({tag, "_rs"},     32'(o.rs),   32'(e.rs));
      check({tag, "_width"},  o.width,  e.width);
      check({tag, "_stable"}, 32'(o.stable), 32'(e.stable));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge with reset asserted; releases it and checks the init.
  task automatic run_init(input string tag, input bit poke);
    int r, idle;
    check({tag, "_rst_e"},    32'(bus.oLCD_E), 0);
    check({tag, "_rst_data"}, 32'(bus.oLCD_Data), 0);
    check({tag, "_rst_rs"},   32'(bus.oLCD_RS), 0);
    check({tag, "_rst_rw"},   32'(bus.oLCD_RW), 0);
    check({tag, "_rst_rdy"},  32'(bus.oReady), 0);
    check({tag, "_rst_done"}, 32'(bus.oInitDone), 0);
    rst_n = 1'b1;
    r = cyc;
    obs_q.delete();
    exp_q.delete();
    idle = exp_init(r);
    if (poke) begin
      bus.iValid = 1'b1;
      bus.iData  = 8'($urandom);
      bus.iRS    = 1'($urandom);
    end
    wait_until(r + 100);
    check({tag, "_mid_rdy"},  32'(bus.oReady), 0);
    check({tag, "_mid_done"}, 32'(bus.oInitDone), 0);
    bus.iValid = 1'b0;
    wait_until(idle - 1);
    check({tag, "_pre_rdy"},  32'(bus.oReady), 0);
    check({tag, "_pre_done"}, 32'(bus.oInitDone), 0);
    wait_until(idle);
    check({tag, "_rdy"},  32'(bus.oReady), 1);
    check({tag, "_done"}, 32'(bus.oInitDone), 1);
    compare_pulses(tag);
  endtask

  // Single-cycle request from IDLE after idle_gap extra idle cycles.
  task automatic xfer(input string tag, input logic [7:0] b, input logic rs, input int idle_gap);
    int a, rdy;
    repeat (idle_gap) @(negedge clk);
    check({tag, "_idle_rdy"}, 32'(bus.oReady), 1);
    bus.iValid = 1'b1;
    bus.iData  = b;
    bus.iRS    = rs;
    a = cyc + 1;
    @(negedge clk);
    bus.iValid = 1'b0;
    bus.iData  = 8'($urandom);
    bus.iRS    = 1'($urandom);
    check({tag, "_busy"}, 32'(bus.oReady), 0);
    rdy = exp_byte(a + 1, b, rs);
    wait_until(rdy - 1);
    check({tag, "_pre_rdy"}, 32'(bus.oReady), 0);
    wait_until(rdy);
    check({tag, "_rdy"}, 32'(bus.oReady), 1);
    compare_pulses(tag);
  endtask

  initial begin
    int a1, a2, rdy1, rdy2, rise;
    logic [7:0] b;
    logic       rs;

    bus.iValid = 1'b0;
    bus.iData  = '0;
    bus.iRS    = 1'b0;
    repeat (3) @(negedge clk);

    // Power-up init with a request held during init (must be ignored).
    run_init("init", 1'b1);

    // Plain character, then clear command with its long gap.
    xfer("char48", 8'h48, 1'b1, 0);
    xfer("clear", 8'h01, 1'b0, 2);

    // iValid held across two transfers: one accept per IDLE visit.
    bus.iValid = 1'b1;
    bus.iData  = 8'h48;
    bus.iRS    = 1'b1;
    a1   = cyc + 1;
    rdy1 = exp_byte(a1 + 1, 8'h48, 1'b1);
    wait_until(a1);
    bus.iData = 8'h6F;
    a2   = rdy1 + 1;
    rdy2 = exp_byte(a2 + 1, 8'h6F, 1'b1);
    wait_until(a2);
    bus.iValid = 1'b0;
    check("held_busy", 32'(bus.oReady), 0);
    wait_until(rdy2);
    check("held_rdy", 32'(bus.oReady), 1);
    compare_pulses("held");
    repeat (10) @(negedge clk);
    check("held_no_extra", obs_q.size(), 0);
    check("held_still_rdy", 32'(bus.oReady), 1);

    // Random bytes, biased toward the clear/home codes.
    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        b  = 8'($urandom_range(1, 3));
        rs = 1'($urandom_range(0, 1));
      end
      xfer("rand", b, rs, int'($urandom_range(0, 3)));
    end

    // Reset during E-high of a hi nibble aborts and replays init.
    bus.iValid = 1'b1;
    bus.iData  = 8'h5A;
    bus.iRS    = 1'b1;
    a1 = cyc + 1;
    @(negedge clk);
    bus.iValid = 1'b0;
    rise = a1 + 1 + P_SETUP;
    wait_until(rise + 1);
    check("abort_e_high", 32'(bus.oLCD_E), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_e_low",  32'(bus.oLCD_E), 0);
    check("abort_data",   32'(bus.oLCD_Data), 0);
    check("abort_rdy",    32'(bus.oReady), 0);
    check("abort_done",   32'(bus.oInitDone), 0);
    repeat (2) @(negedge clk);
    run_init("replay", 1'b0);
    xfer("after", 8'h41, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
